// File: rtl/top_interface.sv
// UART-controlled 8-bit ALU: receives operand A, operand B and an opcode over
// 8N1 serial, applies the opcode, and transmits the 8-bit result back on tx.

module baud_gen #(
  parameter int BAUD_DIV = 163
) (
  input  logic clock,
  input  logic reset,
  output logic o_tick
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);
endmodule

module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(NB_DATA - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_sync;
  logic               r_prev;
  logic [3:0]         r_s;
  logic [2:0]         r_n;
  logic [NB_DATA-1:0] r_b;
  logic               r_done;
  logic               w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= w_rx;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (r_prev && !w_rx) begin
            r_state <= S_START;
            r_s     <= '0;
          end
        S_START:
          if (i_tick) begin
            // Re-sample near mid start bit; a line back at 1 is treated as a glitch.
            if (r_s == 4'd7) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= w_rx ? S_IDLE : S_DATA;
            end else r_s <= r_s + 1'b1;
          end
        S_DATA:
          if (i_tick) begin
            if (r_s == 4'd15) begin
              r_s <= '0;
              r_b <= {w_rx, r_b[NB_DATA-1:1]};
              if (r_n == BIT_LAST) r_state <= S_STOP;
              else r_n <= r_n + 1'b1;
            end else r_s <= r_s + 1'b1;
          end
        default:
          if (i_tick) begin
            if (r_s == STOP_LAST) begin
              r_done  <= w_rx;
              r_state <= S_IDLE;
            end else r_s <= r_s + 1'b1;
          end
      endcase
    end
  end

  assign o_done = r_done;
  assign o_data = r_b;
endmodule

module uart_tx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tick,
  output logic               o_done,
  output logic               o_tx
);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(NB_DATA - 1);

  logic [1:0]         r_state;
  logic [3:0]         r_s;
  logic [2:0]         r_n;
  logic [NB_DATA-1:0] r_b;
  logic               r_tx;
  logic               r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (i_start) begin
            r_b     <= i_data;
            r_s     <= '0;
            r_n     <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        S_START:
          if (i_tick) begin
            if (r_s == 4'd15) begin
              r_s     <= '0;
              r_tx    <= r_b[0];
              r_state <= S_DATA;
            end else r_s <= r_s + 1'b1;
          end
        S_DATA:
          if (i_tick) begin
            if (r_s == 4'd15) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == BIT_LAST) begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_n  <= r_n + 1'b1;
                r_tx <= r_b[1];
              end
            end else r_s <= r_s + 1'b1;
          end
        default:
          if (i_tick) begin
            if (r_s == STOP_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else r_s <= r_s + 1'b1;
          end
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;
endmodule

module alu #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_DATA-1:0] SH_LIM = NB_DATA'(NB_DATA);

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_SRA: o_result = (i_b >= SH_LIM) ? {NB_DATA{i_a[NB_DATA-1]}}
                                         : NB_DATA'($signed(i_a) >>> i_b);
      OP_SRL: o_result = (i_b >= SH_LIM) ? '0 : (i_a >> i_b);
      default: o_result = '0;
    endcase
  end
endmodule

module collector #(
  parameter int NB_DATA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_a,
  output logic [NB_DATA-1:0] o_b,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_tx_start
);
  localparam logic [1:0] WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, SEND = 2'd3;

  logic [1:0]         r_state;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_DATA-1:0] r_result;
  logic               r_tx_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= WAIT_A;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        WAIT_A:  if (i_rx_done) begin r_a <= i_rx_data; r_state <= WAIT_B; end
        WAIT_B:  if (i_rx_done) begin r_b <= i_rx_data; r_state <= WAIT_OP; end
        WAIT_OP:
          if (i_rx_done) begin
            r_result   <= i_alu_result;
            r_tx_start <= 1'b1;
            r_state    <= SEND;
          end
        // Bytes arriving while a result is on the wire are dropped.
        default: if (i_tx_done) r_state <= WAIT_A;
      endcase
    end
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_result   = r_result;
  assign o_tx_start = r_tx_start;
endmodule

module top_interface #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int BAUD_DIV = 163,
  parameter int SB_TICK  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic tx
);
  logic               w_tick;
  logic               w_rx_done;
  logic [NB_DATA-1:0] w_rx_data;
  logic [NB_DATA-1:0] w_a;
  logic [NB_DATA-1:0] w_b;
  logic [NB_DATA-1:0] w_alu_result;
  logic [NB_DATA-1:0] w_result;
  logic               w_tx_start;
  logic               w_tx_done;

  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clock(clock), .reset(reset), .o_tick(w_tick)
  );

  uart_rx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) u_rx (
    .clock(clock), .reset(reset), .i_rx(rx), .i_tick(w_tick),
    .o_done(w_rx_done), .o_data(w_rx_data)
  );

  // The opcode byte feeds the ALU directly so its result is captured on the same rx_done.
  alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .i_a(w_a), .i_b(w_b), .i_op(w_rx_data[NB_OP-1:0]), .o_result(w_alu_result)
  );

  collector #(.NB_DATA(NB_DATA)) u_col (
    .clock(clock), .reset(reset), .i_rx_done(w_rx_done), .i_rx_data(w_rx_data),
    .i_alu_result(w_alu_result), .i_tx_done(w_tx_done),
    .o_a(w_a), .o_b(w_b), .o_result(w_result), .o_tx_start(w_tx_start)
  );

  uart_tx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) u_tx (
    .clock(clock), .reset(reset), .i_start(w_tx_start), .i_data(w_result),
    .i_tick(w_tick), .o_done(w_tx_done), .o_tx(tx)
  );
endmodule

// File: tb/tb_top_interface.sv
// Directed bench for top_interface: drives UART byte triples on rx and decodes the
// result frame on tx; a short baud divider keeps the run brief.

module tb_top_interface;
  localparam int BAUD_DIV = 4;
  localparam int BIT      = 16 * BAUD_DIV;
  localparam int TIMEOUT  = 40 * BIT;

  logic clock;
  logic reset;
  logic rx;
  logic tx;

  int n_pass  = 0;
  int n_total = 0;

  top_interface #(.BAUD_DIV(BAUD_DIV)) dut (
    .clock(clock), .reset(reset), .rx(rx), .tx(tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clock);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic capture(output logic [7:0] data, output logic stop_bit,
                         output logic found, input int limit);
    int waited = 0;
    data = '0; stop_bit = 1'b0; found = 1'b0;
    while (tx !== 1'b0 && waited < limit) begin
      @(negedge clock);
      waited++;
    end
    if (tx === 1'b0) begin
      found = 1'b1;
      repeat (BIT / 2) @(negedge clock);
      if (tx !== 1'b0) found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clock);
        data[i] = tx;
      end
      repeat (BIT) @(negedge clock);
      stop_bit = tx;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp);
    logic [7:0] d;
    logic       s;
    logic       f;
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    fork
      send_byte(op, 1'b1);
      capture(d, s, f, TIMEOUT);
    join
    check({tag, "_frame"}, {7'd0, f}, 8'd1);
    check({tag, "_data"}, d, exp);
    check({tag, "_stop"}, {7'd0, s}, 8'd1);
    repeat (BIT) @(negedge clock);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check(tag, 8'(bad), 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clock);
    check("reset_tx", {7'd0, tx}, 8'd1);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_tx", {7'd0, tx}, 8'd1);

    run_op("add", 8'h05, 8'h03, 8'h20, 8'h08);
    run_op("sub_wrap", 8'h03, 8'h05, 8'h22, 8'hFE);
    run_op("sra", 8'h80, 8'h01, 8'h03, 8'hC0);
    run_op("srl", 8'h80, 8'h01, 8'h02, 8'h40);
    run_op("nor", 8'hF0, 8'h3C, 8'h27, 8'h03);
    run_op("bad_op", 8'hAA, 8'h55, 8'h3F, 8'h00);
    run_op("sra_big", 8'h90, 8'h09, 8'h03, 8'hFF);
    run_op("srl_big", 8'hFF, 8'h08, 8'h02, 8'h00);

    // Framing error: stop bit low; the byte must not count as operand A.
    send_byte(8'h11, 1'b0);
    quiet_window("framing_quiet", BIT);
    run_op("after_frame_err", 8'h22, 8'h33, 8'h24, 8'h22);

    // Reset in the middle of operand B aborts everything.
    send_byte(8'h07, 1'b1);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clock);
    reset = 1'b1;
    quiet_window("rst_hold_quiet", 20);
    rx    = 1'b1;
    reset = 1'b0;
    quiet_window("rst_after_quiet", 20 * BIT);
    run_op("after_reset", 8'h01, 8'h01, 8'h20, 8'h02);

    // Start glitch shorter than half a bit.
    rx = 1'b0;
    repeat (BIT / 4) @(negedge clock);
    rx = 1'b1;
    quiet_window("glitch_quiet", 12 * BIT);
    run_op("after_glitch", 8'h05, 8'h03, 8'h20, 8'h08);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
